// File: rtl/can_pkg.sv
// can_pkg
//   Shared types and constants for the CAN error/overload frame controller.
//   - can_errovl_state_t : sequencer state encoding
//   - CAN_ERR_*          : lastError codes
//   - CAN_*_LEN          : default bit-length constants (also used by the MAC)
//   - can_err_code()     : priority encoder for the active-low error strobes
package can_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ERR_FLAG,
    ST_ERR_ECHO,
    ST_ERR_DELIM,
    ST_OVL_FLAG,
    ST_OVL_ECHO,
    ST_OVL_DELIM,
    ST_INTERMISSION
  } can_errovl_state_t;

  localparam logic [2:0] CAN_ERR_NONE  = 3'd0;
  localparam logic [2:0] CAN_ERR_BIT   = 3'd1;
  localparam logic [2:0] CAN_ERR_STUFF = 3'd2;
  localparam logic [2:0] CAN_ERR_FORM  = 3'd3;
  localparam logic [2:0] CAN_ERR_CRC   = 3'd4;
  localparam logic [2:0] CAN_ERR_EOF   = 3'd5;

  localparam int unsigned CAN_FLAG_LEN         = 6;
  localparam int unsigned CAN_DELIM_LEN        = 8;
  localparam int unsigned CAN_INTERMISSION_LEN = 3;
  localparam int unsigned CAN_ECHO_MAX         = 7;
  localparam int unsigned CAN_MAX_OVERLOAD     = 2;

  // Highest-priority error wins: bit > stuff > form > crc > eof.
  function automatic logic [2:0] can_err_code(input logic bit_n, input logic stuff_n,
                                              input logic form_n, input logic crc_n,
                                              input logic eof_n);
    if (!bit_n)        return CAN_ERR_BIT;
    else if (!stuff_n) return CAN_ERR_STUFF;
    else if (!form_n)  return CAN_ERR_FORM;
    else if (!crc_n)   return CAN_ERR_CRC;
    else if (!eof_n)   return CAN_ERR_EOF;
    else               return CAN_ERR_NONE;
  endfunction

endpackage

// File: rtl/can_bit_counter.sv
// can_bit_counter
//   CNT_W-wide saturating counter, advancing only when en_i is high.
//   Ports:
//     clk_i, rst_ni   : clock, synchronous active-low reset
//     en_i            : bit strobe (samplePoint)
//     clr_i           : clear to 0 (highest priority)
//     load_one_i      : load 1
//     inc_i           : increment, saturating at term_i
//     term_i          : terminal value
//     at_term_o       : count equals term_i
module can_bit_counter #(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic             load_one_i,
  input  logic             inc_i,
  input  logic [CNT_W-1:0] term_i,
  output logic             at_term_o
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (en_i) begin
      if (clr_i) begin
        cnt_q <= '0;
      end else if (load_one_i) begin
        cnt_q <= CNT_W'(1);
      end else if (inc_i && (cnt_q < term_i)) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign at_term_o = (cnt_q == term_i);

endmodule

// File: rtl/can_error_overload_ctrl.sv
// can_error_overload_ctrl
//   CAN error/overload frame sequencer: error flag (active/passive), flag echo,
//   delimiter, intermission and bounded overload frames. Advances only on
//   samplePoint strobes; all outputs registered.
//   Ports:
//     clock, reset        : clock, synchronous active-low reset
//     samplePoint         : one-cycle strobe per bit time
//     canRX               : sampled bus level (0 = dominant)
//     bitErro..eofErro    : active-low error strobes
//     overloadFlag        : active-low overload request
//     errorPassive        : 1 = passive (recessive) error flag
//     canTX               : bit to drive (0 = dominant)
//     erro                : active-low, 0 in error-frame states
//     interframe          : 1 during intermission
//     overloadActive      : 1 during overload flag/echo/delimiter
//     lastError           : code of most recent error
//     dominantStuck       : one-cycle pulse when echo exceeds ECHO_MAX
module can_error_overload_ctrl
  import can_pkg::*;
#(
  parameter int unsigned FLAG_LEN         = CAN_FLAG_LEN,
  parameter int unsigned DELIM_LEN        = CAN_DELIM_LEN,
  parameter int unsigned INTERMISSION_LEN = CAN_INTERMISSION_LEN,
  parameter int unsigned ECHO_MAX         = CAN_ECHO_MAX,
  parameter int unsigned MAX_OVERLOAD     = CAN_MAX_OVERLOAD,
  parameter int unsigned CNT_W            = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       samplePoint,
  input  logic       canRX,
  input  logic       bitErro,
  input  logic       stuffErro,
  input  logic       formErro,
  input  logic       crcErro,
  input  logic       eofErro,
  input  logic       overloadFlag,
  input  logic       errorPassive,
  output logic       canTX,
  output logic       erro,
  output logic       interframe,
  output logic       overloadActive,
  output logic [2:0] lastError,
  output logic       dominantStuck
);

  // Phase counter terminals are "last bit" values: the phase ends on the
  // sample where the counter already holds LEN-1.
  localparam logic [CNT_W-1:0] FLAG_TERM  = CNT_W'(FLAG_LEN - 1);
  localparam logic [CNT_W-1:0] DELIM_TERM = CNT_W'(DELIM_LEN - 1);
  localparam logic [CNT_W-1:0] INT_TERM   = CNT_W'(INTERMISSION_LEN - 1);
  localparam logic [CNT_W-1:0] ECHO_TERM  = CNT_W'(ECHO_MAX - 1);
  localparam logic [CNT_W-1:0] OVL_TERM   = CNT_W'(MAX_OVERLOAD);

  can_errovl_state_t state_q, state_d;
  logic       canTX_q, canTX_d;
  logic       erro_q, erro_d;
  logic       interframe_q, interframe_d;
  logic       ovlActive_q, ovlActive_d;
  logic [2:0] lastError_q, lastError_d;
  logic       dStuck_q, dStuck_d;

  logic             ph_clr, ph_load_one, ph_inc, ph_at_term;
  logic [CNT_W-1:0] ph_term;
  logic             ov_clr, ov_inc, ov_at_term, ov_below;
  logic             err_any;

  assign err_any  = ~&{bitErro, stuffErro, formErro, crcErro, eofErro};
  assign ov_below = ~ov_at_term;

  always_comb begin
    case (state_q)
      ST_ERR_FLAG, ST_OVL_FLAG:   ph_term = FLAG_TERM;
      ST_ERR_ECHO, ST_OVL_ECHO:   ph_term = ECHO_TERM;
      ST_ERR_DELIM, ST_OVL_DELIM: ph_term = DELIM_TERM;
      ST_INTERMISSION:            ph_term = INT_TERM;
      default:                    ph_term = '0;
    endcase
  end

  can_bit_counter #(.CNT_W(CNT_W)) u_phase_cnt (
    .clk_i      (clock),
    .rst_ni     (reset),
    .en_i       (samplePoint),
    .clr_i      (ph_clr),
    .load_one_i (ph_load_one),
    .inc_i      (ph_inc),
    .term_i     (ph_term),
    .at_term_o  (ph_at_term)
  );

  can_bit_counter #(.CNT_W(CNT_W)) u_ovl_cnt (
    .clk_i      (clock),
    .rst_ni     (reset),
    .en_i       (samplePoint),
    .clr_i      (ov_clr),
    .load_one_i (1'b0),
    .inc_i      (ov_inc),
    .term_i     (OVL_TERM),
    .at_term_o  (ov_at_term)
  );

  always_comb begin
    state_d      = state_q;
    canTX_d      = canTX_q;
    erro_d       = erro_q;
    interframe_d = interframe_q;
    ovlActive_d  = ovlActive_q;
    lastError_d  = lastError_q;
    dStuck_d     = 1'b0;
    ph_clr       = 1'b0;
    ph_load_one  = 1'b0;
    ph_inc       = 1'b0;
    ov_clr       = 1'b0;
    ov_inc       = 1'b0;

    if (samplePoint) begin
      case (state_q)
        ST_IDLE: begin
          if (err_any) begin
            state_d     = ST_ERR_FLAG;
            lastError_d = can_err_code(bitErro, stuffErro, formErro, crcErro, eofErro);
            ph_clr      = 1'b1;
          end else if (!overloadFlag && ov_below) begin
            state_d = ST_OVL_FLAG;
            ov_inc  = 1'b1;
            ph_clr  = 1'b1;
          end
        end
        ST_ERR_FLAG, ST_OVL_FLAG: begin
          if (ph_at_term) begin
            state_d = (state_q == ST_ERR_FLAG) ? ST_ERR_ECHO : ST_OVL_ECHO;
            ph_clr  = 1'b1;
          end else begin
            ph_inc = 1'b1;
          end
        end
        ST_ERR_ECHO, ST_OVL_ECHO: begin
          if (canRX) begin
            // The first recessive bit is also the first delimiter bit.
            state_d     = (state_q == ST_ERR_ECHO) ? ST_ERR_DELIM : ST_OVL_DELIM;
            ph_load_one = 1'b1;
          end else if (ph_at_term) begin
            dStuck_d = 1'b1;
            ph_clr   = 1'b1;
          end else begin
            ph_inc = 1'b1;
          end
        end
        ST_ERR_DELIM, ST_OVL_DELIM: begin
          if (!canRX) begin
            state_d     = ST_ERR_FLAG;
            lastError_d = CAN_ERR_BIT;
            ph_clr      = 1'b1;
          end else if (ph_at_term) begin
            state_d = ST_INTERMISSION;
            ph_clr  = 1'b1;
          end else begin
            ph_inc = 1'b1;
          end
        end
        ST_INTERMISSION: begin
          // Last bit: recessive closes the gap, dominant is taken as SOF.
          if (ph_at_term) begin
            state_d = ST_IDLE;
            ph_clr  = 1'b1;
            ov_clr  = 1'b1;
          end else if (!canRX) begin
            if (ov_below) begin
              state_d = ST_OVL_FLAG;
              ov_inc  = 1'b1;
              ph_clr  = 1'b1;
            end else begin
              state_d = ST_IDLE;
              ph_clr  = 1'b1;
              ov_clr  = 1'b1;
            end
          end else begin
            ph_inc = 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          ph_clr  = 1'b1;
          ov_clr  = 1'b1;
        end
      endcase

      // Outputs are decoded from the next state so they register together.
      if (state_d == ST_ERR_FLAG) begin
        canTX_d = errorPassive;
      end else if (state_d == ST_OVL_FLAG) begin
        canTX_d = 1'b0;
      end else begin
        canTX_d = 1'b1;
      end
      erro_d       = !(state_d inside {ST_ERR_FLAG, ST_ERR_ECHO, ST_ERR_DELIM});
      interframe_d = (state_d == ST_INTERMISSION);
      ovlActive_d  = (state_d inside {ST_OVL_FLAG, ST_OVL_ECHO, ST_OVL_DELIM});
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      canTX_q      <= 1'b1;
      erro_q       <= 1'b1;
      interframe_q <= 1'b0;
      ovlActive_q  <= 1'b0;
      lastError_q  <= CAN_ERR_NONE;
      dStuck_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      canTX_q      <= canTX_d;
      erro_q       <= erro_d;
      interframe_q <= interframe_d;
      ovlActive_q  <= ovlActive_d;
      lastError_q  <= lastError_d;
      dStuck_q     <= dStuck_d;
    end
  end

  assign canTX          = canTX_q;
  assign erro           = erro_q;
  assign interframe     = interframe_q;
  assign overloadActive = ovlActive_q;
  assign lastError      = lastError_q;
  assign dominantStuck  = dStuck_q;

endmodule

// File: tb/tb_can_error_overload_ctrl.sv
// tb_can_error_overload_ctrl
//   Directed bench for can_error_overload_ctrl. Observed outputs are packed as
//   {canTX, erro, interframe, overloadActive, dominantStuck, lastError[2:0]}.
module tb_can_error_overload_ctrl;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       samplePoint = 1'b0;
  logic       canRX = 1'b1;
  logic       bitErro = 1'b1, stuffErro = 1'b1, formErro = 1'b1, crcErro = 1'b1, eofErro = 1'b1;
  logic       overloadFlag = 1'b1;
  logic       errorPassive = 1'b0;
  logic       canTX, erro, interframe, overloadActive, dominantStuck;
  logic [2:0] lastError;
  logic [7:0] obs;
  logic [7:0] e;

  int errors = 0;
  int checks = 0;

  localparam logic [4:0] NOERR = 5'b11111;

  can_error_overload_ctrl #(
    .FLAG_LEN         (6),
    .DELIM_LEN        (8),
    .INTERMISSION_LEN (3),
    .ECHO_MAX         (7),
    .MAX_OVERLOAD     (2),
    .CNT_W            (4)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .samplePoint    (samplePoint),
    .canRX          (canRX),
    .bitErro        (bitErro),
    .stuffErro      (stuffErro),
    .formErro       (formErro),
    .crcErro        (crcErro),
    .eofErro        (eofErro),
    .overloadFlag   (overloadFlag),
    .errorPassive   (errorPassive),
    .canTX          (canTX),
    .erro           (erro),
    .interframe     (interframe),
    .overloadActive (overloadActive),
    .lastError      (lastError),
    .dominantStuck  (dominantStuck)
  );

  always #5 clock = ~clock;

  assign obs = {canTX, erro, interframe, overloadActive, dominantStuck, lastError};

  function automatic logic [7:0] pk(input logic tx, input logic er, input logic ifr,
                                    input logic ov, input logic ds, input logic [2:0] le);
    return {tx, er, ifr, ov, ds, le};
  endfunction

  // One bit time: strobe on one clock, idle on the next. Returns at the
  // negedge after the sample edge, so outputs show that decision.
  task automatic send_bit(input logic rx, input logic [4:0] errs_n, input logic ovl_n);
    @(negedge clock);
    canRX = rx;
    {bitErro, stuffErro, formErro, crcErro, eofErro} = errs_n;
    overloadFlag = ovl_n;
    samplePoint = 1'b1;
    @(negedge clock);
    samplePoint = 1'b0;
    {bitErro, stuffErro, formErro, crcErro, eofErro} = NOERR;
    overloadFlag = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic flag_bits();
    for (int i = 0; i < 6; i++) send_bit(1'b0, NOERR, 1'b1);
  endtask

  task automatic recessive_bits(input int n);
    for (int i = 0; i < n; i++) send_bit(1'b1, NOERR, 1'b1);
  endtask

  task automatic test_reset();
    @(negedge clock);
    reset = 1'b0;
    samplePoint = 1'b1;
    bitErro = 1'b0;
    @(negedge clock);
    @(negedge clock);
    e = pk(1, 1, 0, 0, 0, 0);
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL reset_state act=%b exp=%b", obs, e);
    end
    samplePoint = 1'b0;
    bitErro = 1'b1;
    reset = 1'b1;
  endtask

  task automatic test_active_error();
    recessive_bits(9);
    e = pk(1, 1, 0, 0, 0, 0);
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL act_idle act=%b exp=%b", obs, e);
    end
    send_bit(1'b1, 5'b10111, 1'b1);
    e = pk(0, 0, 0, 0, 0, 2);
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL act_start act=%b exp=%b", obs, e);
    end
    @(negedge clock);
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL act_hold_nosample act=%b exp=%b", obs, e);
    end
    for (int b = 11; b <= 16; b++) begin
      send_bit(1'b0, NOERR, 1'b1);
      e = (b < 16) ? pk(0, 0, 0, 0, 0, 2) : pk(1, 0, 0, 0, 0, 2);
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL act_flag sample=%0d act=%b exp=%b", b, obs, e);
      end
    end
    for (int b = 17; b <= 27; b++) begin
      send_bit(1'b1, NOERR, 1'b1);
      if (b < 24)      e = pk(1, 0, 0, 0, 0, 2);
      else if (b < 27) e = pk(1, 1, 1, 0, 0, 2);
      else             e = pk(1, 1, 0, 0, 0, 2);
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL act_delim_int sample=%0d act=%b exp=%b", b, obs, e);
      end
    end
  endtask

  task automatic test_passive_error();
    errorPassive = 1'b1;
    send_bit(1'b1, 5'b11101, 1'b1);
    for (int k = 0; k <= 6; k++) begin
      if (k > 0) send_bit(1'b1, NOERR, 1'b1);
      e = pk(1, 0, 0, 0, 0, 4);
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL passive_flag bit=%0d act=%b exp=%b", k, obs, e);
      end
    end
    recessive_bits(8);
    e = pk(1, 1, 1, 0, 0, 4);
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL passive_int act=%b exp=%b", obs, e);
    end
    recessive_bits(3);
    e = pk(1, 1, 0, 0, 0, 4);
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL passive_idle act=%b exp=%b", obs, e);
    end
    errorPassive = 1'b0;
  endtask

  task automatic test_simultaneous();
    send_bit(1'b1, 5'b01110, 1'b0);
    e = pk(0, 0, 0, 0, 0, 1);
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL simul_err_wins act=%b exp=%b", obs, e);
    end
    send_bit(1'b0, NOERR, 1'b1);
    send_bit(1'b0, NOERR, 1'b1);
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL simul_flag2 act=%b exp=%b", obs, e);
    end
  endtask

  task automatic test_reset_mid_flag();
    do_reset();
    e = pk(1, 1, 0, 0, 0, 0);
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL midflag_reset act=%b exp=%b", obs, e);
    end
    send_bit(1'b1, NOERR, 1'b1);
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL midflag_idle act=%b exp=%b", obs, e);
    end
    send_bit(1'b1, NOERR, 1'b0);
    e = pk(0, 1, 0, 1, 0, 0);
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL idle_overload act=%b exp=%b", obs, e);
    end
    do_reset();
  endtask

  task automatic test_overload_chain();
    send_bit(1'b1, 5'b11011, 1'b1);
    flag_bits();
    recessive_bits(8);
    e = pk(1, 1, 1, 0, 0, 3);
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL ovl_first_int act=%b exp=%b", obs, e);
    end
    for (int n = 1; n <= 2; n++) begin
      send_bit(1'b0, NOERR, 1'b1);
      e = pk(0, 1, 0, 1, 0, 3);
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL ovl_enter n=%0d act=%b exp=%b", n, obs, e);
      end
      flag_bits();
      e = pk(1, 1, 0, 1, 0, 3);
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL ovl_echo n=%0d act=%b exp=%b", n, obs, e);
      end
      recessive_bits(1);
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL ovl_delim n=%0d act=%b exp=%b", n, obs, e);
      end
      recessive_bits(7);
      e = pk(1, 1, 1, 0, 0, 3);
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL ovl_int n=%0d act=%b exp=%b", n, obs, e);
      end
    end
    send_bit(1'b0, NOERR, 1'b1);
    e = pk(1, 1, 0, 0, 0, 3);
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL ovl_limit_idle act=%b exp=%b", obs, e);
    end
    send_bit(1'b1, NOERR, 1'b0);
    e = pk(0, 1, 0, 1, 0, 3);
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL ovl_count_cleared act=%b exp=%b", obs, e);
    end
    flag_bits();
    recessive_bits(8);
    recessive_bits(2);
    e = pk(1, 1, 1, 0, 0, 3);
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL int_bit2 act=%b exp=%b", obs, e);
    end
    send_bit(1'b0, NOERR, 1'b1);
    e = pk(1, 1, 0, 0, 0, 3);
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL int_last_sof act=%b exp=%b", obs, e);
    end
  endtask

  task automatic test_echo_stall();
    do_reset();
    send_bit(1'b1, 5'b11110, 1'b1);
    flag_bits();
    for (int k = 1; k <= 7; k++) begin
      send_bit(1'b0, NOERR, 1'b1);
      e = (k < 7) ? pk(1, 0, 0, 0, 0, 5) : pk(1, 0, 0, 0, 1, 5);
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL echo_dom k=%0d act=%b exp=%b", k, obs, e);
      end
    end
    @(negedge clock);
    e = pk(1, 0, 0, 0, 0, 5);
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL stuck_pulse_clear act=%b exp=%b", obs, e);
    end
    recessive_bits(3);
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL echo_to_delim act=%b exp=%b", obs, e);
    end
    send_bit(1'b0, NOERR, 1'b1);
    e = pk(0, 0, 0, 0, 0, 1);
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL delim_bit_error act=%b exp=%b", obs, e);
    end
  endtask

  initial begin
    test_reset();
    test_active_error();
    test_passive_error();
    test_simultaneous();
    test_reset_mid_flag();
    test_overload_chain();
    test_echo_stall();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1);
  end

endmodule

// File: doc/can_error_overload_ctrl.md
# can_error_overload_ctrl

Parametrised CAN error/overload frame controller. It replaces the single-state error latch with a full fault-signalling sequencer: error flag (active or passive), flag echo, error/overload delimiter, intermission, and bounded overload frames. It sits between the bit-level receive path (stuff/CRC/form/EOF checkers) and the TX bit driver. All decisions advance only on `samplePoint` strobes.

## Interface
- `FLAG_LEN`, 6: flag length in bits (error and overload).
- `DELIM_LEN`, 8: delimiter length in bits, including the first recessive bit.
- `INTERMISSION_LEN`, 3: intermission length in bits.
- `ECHO_MAX`, 7: maximum dominant bits tolerated after own flag before `dominantStuck`.
- `MAX_OVERLOAD`, 2: maximum consecutive overload frames per interframe gap.
- `CNT_W`, 4: bit counter width; must hold max(FLAG_LEN, DELIM_LEN, ECHO_MAX, INTERMISSION_LEN).

Ports:
- `clock` in 1: system clock.
- `reset` in 1: synchronous, active-low reset.
- `samplePoint` in 1: one-cycle strobe per bit time.
- `canRX` in 1: sampled bus level (0 = dominant); valid when `samplePoint`=1.
- `bitErro`, `stuffErro`, `formErro`, `crcErro`, `eofErro` in 1 each: active-low error strobes, valid at `samplePoint`.
- `overloadFlag` in 1: active-low overload request from MAC.
- `errorPassive` in 1: node mode; 1 = transmit passive (recessive) error flag.
- `canTX` out 1: bit to drive (0 = dominant).
- `erro` out 1: active-low; 0 while any error-frame state is active.
- `interframe` out 1: 1 during INTERMISSION.
- `overloadActive` out 1: 1 during overload flag, echo, or delimiter.
- `lastError` out 3: code of the most recent error (0 none, 1 bit, 2 stuff, 3 form, 4 crc, 5 eof).
- `dominantStuck` out 1: one-cycle pulse when the echo phase exceeds `ECHO_MAX`.

## Operation
- States: IDLE, ERR_FLAG, ERR_ECHO, ERR_DELIM, OVL_FLAG, OVL_ECHO, OVL_DELIM, INTERMISSION. State and counters change only on clock edges with `samplePoint`=1.
- IDLE to ERR_FLAG: any error strobe low. `lastError` captures the highest-priority code (bit > stuff > form > crc > eof).
- IDLE to OVL_FLAG: `overloadFlag`=0 and the overload count is below `MAX_OVERLOAD`. If both an error and an overload are requested, the error wins.
- ERR_FLAG: `canTX` = `errorPassive` ? 1 : 0 for `FLAG_LEN` bits, then ERR_ECHO.
- OVL_FLAG: always dominant for `FLAG_LEN` bits, then OVL_ECHO.
- ECHO states: `canTX`=1; wait for the first `canRX`=1.
  - On that bit, go to the matching DELIM state with the counter at 1.
  - After `ECHO_MAX` consecutive dominant bits, pulse `dominantStuck` and restart the counter; the state does not change.
- DELIM states: count recessive bits up to `DELIM_LEN`, then INTERMISSION. A dominant bit during delimiter means bit error: go to ERR_FLAG with `lastError`=1.
- INTERMISSION: `canTX`=1, `interframe`=1.
  - Dominant in bit 1 to `INTERMISSION_LEN`-1: go to OVL_FLAG if count < `MAX_OVERLOAD`, else IDLE.
  - Dominant in the last bit: treat as SOF, go to IDLE.
  - After `INTERMISSION_LEN` recessive bits: go to IDLE.
- Overload count increments on entry to OVL_FLAG and clears on any entry to IDLE.
- Error strobes are ignored outside IDLE, except for the delimiter bit-error rule above.
- Counters saturate at their terminal value and never wrap.

## Timing
- Reset values (`reset`=0 at any clock edge, including mid-frame): state IDLE, counters 0, `canTX`=1, `erro`=1, `interframe`=0, `overloadActive`=0, `lastError`=0, `dominantStuck`=0.
- All outputs are registered. `canTX` reflects a decision one clock after the deciding `samplePoint` edge and holds until the next decision.
- Error detected at sample N: first flag bit is driven for bit N+1.
- `lastError` updates in the same cycle `erro` falls, and holds until the next error or reset.
- `samplePoint`=0 cycles: no state, counter, or output change, except that `dominantStuck` returns to 0.

## Structure
- Package `can_pkg`:
  - state enum `can_errovl_state_t`;
  - error code constants `CAN_ERR_NONE`…`CAN_ERR_EOF`;
  - default bit-length constants, shared with the MAC.
- One sub-module `can_bit_counter`: `CNT_W`-wide saturating counter with clear, enable (`samplePoint`), and terminal-compare output. It is instantiated once for the flag/echo/delimiter/intermission phases and once for the overload count.

## Test plan
- Active error: `stuffErro`=0 at sample 10 → `canTX`=0 for samples 11–16, `erro`=0, `lastError`=2; with `canRX`=1 from 17, delimiter ends at 24, `interframe`=1 for 25–27, then IDLE with `erro`=1.
- Passive error: `errorPassive`=1 with `crcErro`=0 → `canTX` stays 1 throughout the flag; `lastError`=4.
- Simultaneous `bitErro`=0, `eofErro`=0, and `overloadFlag`=0 → ERR_FLAG entered, `lastError`=1, no overload.
- Overload chain: dominant in intermission bit 1 three times → two overload frames (`overloadActive`=1); third dominant → IDLE; overload count clears.
- Echo stall: `canRX`=0 held for 7 bits after the flag → `dominantStuck` pulses one cycle; later recessive → ERR_DELIM.
- Reset mid-flag: `reset`=0 at flag bit 3 → next cycle `canTX`=1, `erro`=1, state IDLE, `lastError`=0.
